// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings and helpers for the byte-lane data memory
package dm_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } dm_state_e;

  // Largest legal req_size encoding for a given data word width.
  function automatic logic [1:0] max_size(input int data_w);
    return (data_w == 64) ? SZ_DWORD : SZ_WORD;
  endfunction

endpackage

// File: rtl/dm_rsp_pipe.sv
// rtl/dm_rsp_pipe.sv - fixed-latency response shift register {valid, err, rdata}
module dm_rsp_pipe #(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata
);

  logic [READ_LAT-1:0] r_valid;
  logic [READ_LAT-1:0] r_err;
  logic [DATA_W-1:0]   r_rdata [READ_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < READ_LAT; i++) r_rdata[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_err;
      r_rdata[0] <= i_rdata;
      for (int i = 1; i < READ_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
        r_rdata[i] <= r_rdata[i-1];
      end
    end
  end

  assign o_valid = r_valid[READ_LAT-1];
  assign o_err   = r_err[READ_LAT-1];
  assign o_rdata = r_rdata[READ_LAT-1];

endmodule

// File: rtl/dm_bytelane.sv
// rtl/dm_bytelane.sv - big-endian byte-addressable data memory with pipelined responses
module dm_bytelane #(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH_BYTES    = 1024,
  parameter int    READ_LAT       = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = "DM.list"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              clear_busy
);
  import dm_pkg::*;

  localparam int         NB     = DATA_W / 8;
  localparam int         NWORDS = DEPTH_BYTES / NB;
  localparam int         AW     = $clog2(DEPTH_BYTES);
  localparam int         LB     = $clog2(NB);
  localparam int         WIW    = AW - LB;
  localparam logic [1:0] MAX_SZ = max_size(DATA_W);

  dm_state_e        r_state;
  logic [WIW-1:0]   r_clr_idx;
  logic             r_ready;
  logic             r_clear_busy;
  logic [7:0]       r_mem [DEPTH_BYTES];

  logic [3:0]        w_nbytes;
  logic [32:0]       w_end;
  logic              w_size_bad;
  logic              w_misalign;
  logic              w_oor;
  logic              w_err;
  logic              w_accept;
  logic              w_store;
  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_field;
  logic [DATA_W-1:0] w_hi_mask;
  logic              w_sign;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_pipe_rdata;

  assign w_nbytes   = 4'd1 << req_size;
  assign w_end      = {1'b0, req_addr} + {29'd0, w_nbytes};
  assign w_size_bad = req_size > MAX_SZ;
  assign w_misalign = (req_addr[2:0] & 3'(w_nbytes - 4'd1)) != 3'd0;
  assign w_oor      = w_end > 33'(DEPTH_BYTES);
  assign w_err      = w_size_bad | w_misalign | w_oor;
  assign w_accept   = req_valid & r_ready;
  assign w_store    = w_accept & req_we & ~w_err;
  assign w_idx      = req_addr[AW-1:0];

  // Lowest address lands in the most significant byte of the right-justified field.
  always_comb begin
    w_field = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(w_nbytes)) w_field = {w_field[DATA_W-9:0], r_mem[w_idx + AW'(i)]};
    end
  end

  always_comb begin
    w_hi_mask = '0;
    w_sign    = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        w_hi_mask = DATA_W'(64'hFFFF_FFFF_FFFF_FF00);
        w_sign    = w_field[7];
      end
      SZ_HALF: begin
        w_hi_mask = DATA_W'(64'hFFFF_FFFF_FFFF_0000);
        w_sign    = w_field[15];
      end
      SZ_WORD: begin
        w_hi_mask = DATA_W'(64'hFFFF_FFFF_0000_0000);
        w_sign    = w_field[31];
      end
      default: begin
        w_hi_mask = '0;
        w_sign    = 1'b0;
      end
    endcase
  end

  assign w_ext        = w_field | (w_hi_mask & {DATA_W{w_sign & ~req_unsigned}});
  assign w_pipe_rdata = (w_accept & ~req_we & ~w_err) ? w_ext : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_clr_idx    <= '0;
      r_ready      <= 1'b0;
      r_clear_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      case (r_state)
        ST_RESET: begin
          r_clr_idx <= '0;
          if (CLEAR_ON_RESET != 0) begin
            r_state <= ST_CLEAR;
          end else begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_idx == WIW'(NWORDS - 1)) begin
            r_state      <= ST_RUN;
            r_ready      <= 1'b1;
            r_clear_busy <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_RESET;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array contents survive reset; only the clear sequence or a store changes them.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      for (int b = 0; b < NB; b++) r_mem[{r_clr_idx, LB'(b)}] <= 8'h00;
    end else if (w_store) begin
      for (int b = 0; b < NB; b++) begin
        if (b < int'(w_nbytes))
          r_mem[w_idx + AW'(b)] <= req_wdata[8*(int'(w_nbytes)-1-b) +: 8];
      end
    end
  end

  dm_rsp_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept),
    .i_err   (w_accept & w_err),
    .i_rdata (w_pipe_rdata),
    .o_valid (rsp_valid),
    .o_err   (rsp_err),
    .o_rdata (rsp_rdata)
  );

  assign req_ready  = r_ready;
  assign clear_busy = r_clear_busy;

endmodule
